// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar front end: state encoding, default timing
// constants for a 50 MHz clock, and BCD digit width.
package sonar_pkg;

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        ABORTA      = 4'd6
    } estado_t;

    localparam int DEF_CICLOS_TRIGGER     = 500;
    localparam int DEF_CICLOS_POR_CM      = 2941;
    localparam int DEF_CICLOS_TIMEOUT_ECHO = 1_500_000;
    localparam int DEF_CICLOS_MAX_ECHO    = 2_000_000;

    localparam int BCD_W = 4;

    // Half a centimetre of echo: the first increment lands here so the
    // result is rounded to nearest instead of truncated.
    function automatic int meio_cm(input int ciclos_por_cm);
        return ciclos_por_cm / 2;
    endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-decade cascaded BCD counter with synchronous clear; saturates at 999.
module contador_bcd_3dig
    import sonar_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 zera,
    input  logic                 conta,
    output logic [3*BCD_W-1:0]   valor
);

    logic [BCD_W-1:0] unidades;
    logic [BCD_W-1:0] dezenas;
    logic [BCD_W-1:0] centenas;
    logic             saturado;

    assign saturado = (centenas == 4'd9) && (dezenas == 4'd9) && (unidades == 4'd9);

    // Decade cascade: carry ripples only when the lower digits are at 9.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unidades <= 4'd0;
            dezenas  <= 4'd0;
            centenas <= 4'd0;
        end else if (zera) begin
            unidades <= 4'd0;
            dezenas  <= 4'd0;
            centenas <= 4'd0;
        end else if (conta && !saturado) begin
            if (unidades == 4'd9) begin
                unidades <= 4'd0;
                if (dezenas == 4'd9) begin
                    dezenas  <= 4'd0;
                    centenas <= centenas + 4'd1;
                end else begin
                    dezenas <= dezenas + 4'd1;
                end
            end else begin
                unidades <= unidades + 4'd1;
            end
        end
    end

    assign valor = {centenas, dezenas, unidades};

endmodule

// File: rtl/interface_hcsr04_medida.sv
// HC-SR04 front end: issues the trigger pulse, times the echo and reports the
// distance in BCD centimetres (rounded to nearest) or a timeout strobe.
module interface_hcsr04_medida
    import sonar_pkg::*;
#(
    parameter int CICLOS_TRIGGER      = DEF_CICLOS_TRIGGER,
    parameter int CICLOS_POR_CM       = DEF_CICLOS_POR_CM,
    parameter int CICLOS_TIMEOUT_ECHO = DEF_CICLOS_TIMEOUT_ECHO,
    parameter int CICLOS_MAX_ECHO     = DEF_CICLOS_MAX_ECHO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    localparam int LIM_A = (CICLOS_TIMEOUT_ECHO > CICLOS_MAX_ECHO) ? CICLOS_TIMEOUT_ECHO : CICLOS_MAX_ECHO;
    localparam int LIM   = (LIM_A > CICLOS_TRIGGER) ? LIM_A : CICLOS_TRIGGER;
    localparam int CW    = $clog2(LIM + 1);
    localparam int TW    = $clog2(CICLOS_POR_CM + 1);

    estado_t        estado;
    estado_t        prox;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_prox;
    logic [TW-1:0]  tick;
    logic [TW-1:0]  tick_prox;
    logic [TW-1:0]  tick_inc;
    logic [TW-1:0]  alvo;
    logic           primeiro;
    logic           primeiro_prox;
    logic           amostra;
    logic           zera;
    logic           conta;
    logic [11:0]    bcd;
    logic           echo_s1;
    logic           echo_s2;
    logic           echo_s3;
    logic           sobe;
    logic           desce;

    // Echo synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_s3 <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_s3 <= echo_s2;
        end
    end

    assign sobe  = echo_s2 & ~echo_s3;
    assign desce = ~echo_s2 & echo_s3;

    assign tick_inc = tick + {{(TW-1){1'b0}}, 1'b1};
    assign alvo     = primeiro ? TW'(meio_cm(CICLOS_POR_CM)) : TW'(CICLOS_POR_CM);

    // Next-state logic; cnt holds trigger time, echo wait time or echo width
    // (in samples, counting the rise cycle) depending on the state.
    always_comb begin
        prox          = estado;
        cnt_prox      = cnt;
        tick_prox     = tick;
        primeiro_prox = primeiro;
        zera          = 1'b0;
        conta         = 1'b0;
        amostra       = 1'b0;
        case (estado)
            OCIOSO: begin
                if (medir) begin
                    prox = PREPARA;
                end else begin
                    prox = OCIOSO;
                end
            end
            PREPARA: begin
                zera          = 1'b1;
                cnt_prox      = '0;
                tick_prox     = '0;
                primeiro_prox = 1'b1;
                prox          = TRIGGER;
            end
            TRIGGER: begin
                if (cnt == CW'(CICLOS_TRIGGER - 1)) begin
                    cnt_prox = '0;
                    prox     = ESPERA_ECHO;
                end else begin
                    cnt_prox = cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ESPERA_ECHO: begin
                // A rise on the timeout cycle still starts the measurement.
                if (sobe) begin
                    cnt_prox = {{(CW-1){1'b0}}, 1'b1};
                    amostra  = 1'b1;
                    prox     = MEDE;
                end else if (cnt == CW'(CICLOS_TIMEOUT_ECHO - 1)) begin
                    cnt_prox = '0;
                    prox     = ABORTA;
                end else begin
                    cnt_prox = cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            MEDE: begin
                if (desce) begin
                    prox = ARMAZENA;
                end else if (cnt == CW'(CICLOS_MAX_ECHO)) begin
                    prox = ABORTA;
                end else begin
                    cnt_prox = cnt + {{(CW-1){1'b0}}, 1'b1};
                    amostra  = 1'b1;
                end
            end
            ARMAZENA: begin
                cnt_prox = '0;
                prox     = OCIOSO;
            end
            ABORTA: begin
                cnt_prox = '0;
                prox     = OCIOSO;
            end
            default: begin
                cnt_prox = '0;
                prox     = OCIOSO;
            end
        endcase

        if (amostra) begin
            if (tick_inc == alvo) begin
                conta         = 1'b1;
                tick_prox     = '0;
                primeiro_prox = 1'b0;
            end else begin
                tick_prox = tick_inc;
            end
        end else begin
            tick_prox = tick_prox;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            cnt      <= '0;
            tick     <= '0;
            primeiro <= 1'b0;
            trigger  <= 1'b0;
            pronto   <= 1'b0;
            timeout  <= 1'b0;
            medida   <= 12'h000;
        end else begin
            estado   <= prox;
            cnt      <= cnt_prox;
            tick     <= tick_prox;
            primeiro <= primeiro_prox;
            trigger  <= (prox == TRIGGER);
            pronto   <= (prox == ARMAZENA);
            timeout  <= (prox == ABORTA);
            if (prox == ARMAZENA) begin
                medida <= bcd;
            end else begin
                medida <= medida;
            end
        end
    end

    contador_bcd_3dig u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .valor (bcd)
    );

    assign ocupado   = (estado != OCIOSO);
    assign db_estado = estado;

endmodule

// File: tb/tb_interface_hcsr04_medida.sv
// Self-checking bench: per-cycle comparison against event windows computed
// arithmetically from trigger/echo timing, with scaled-down timing constants.
module tb_interface_hcsr04_medida;

    localparam int TRIG = 20;
    localparam int POR  = 11;
    localparam int TOUT = 2000;
    localparam int MAXE = 12000;
    localparam int HALF = POR / 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        timeout;
    logic        ocupado;
    logic [3:0]  db_estado;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int trig_lo, trig_hi, busy_lo, busy_hi, pronto_at, tout_at, med_switch;
    logic [11:0] med_old, med_new, med_cur;
    bit chk_on = 1'b0;

    interface_hcsr04_medida #(
        .CICLOS_TRIGGER      (TRIG),
        .CICLOS_POR_CM       (POR),
        .CICLOS_TIMEOUT_ECHO (TOUT),
        .CICLOS_MAX_ECHO     (MAXE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .pronto    (pronto),
        .timeout   (timeout),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    // Echo width in clocks -> expected BCD distance (first cm at half a cm).
    function automatic logic [11:0] modelo(input int w);
        int cm;
        cm = (w < HALF) ? 0 : (w - HALF) / POR + 1;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    always @(negedge clock) begin
        if (chk_on) begin
            check("trigger", {31'b0, trigger}, {31'b0, (cyc >= trig_lo && cyc <= trig_hi)});
            check("ocupado", {31'b0, ocupado}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
            check("estado_ocioso", {31'b0, (db_estado == 4'd0)}, {31'b0, !(cyc >= busy_lo && cyc <= busy_hi)});
            check("pronto", {31'b0, pronto}, {31'b0, (cyc == pronto_at)});
            check("timeout", {31'b0, timeout}, {31'b0, (cyc == tout_at)});
            check("medida", {20'b0, medida}, {20'b0, (cyc >= med_switch) ? med_new : med_old});
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One request; w > MAXE means the echo is held until the abort.
    task automatic medicao(input int gap, input int w, input bit medir_extra);
        int k, tf, r0, f0, meio;
        @(posedge clock);
        #1;
        k       = cyc;
        trig_lo = k + 2;
        trig_hi = k + TRIG + 1;
        tf      = k + TRIG + 2;
        busy_lo = k + 1;
        r0      = tf + gap + 1;
        f0      = r0 + w;
        med_old = med_cur;
        if (w <= MAXE) begin
            busy_hi    = f0 + 2;
            pronto_at  = f0 + 2;
            tout_at    = -1;
            med_new    = modelo(w);
            med_switch = f0 + 2;
        end else begin
            busy_hi    = r0 + MAXE + 2;
            tout_at    = r0 + MAXE + 2;
            pronto_at  = -1;
            med_new    = med_cur;
        end
        medir = 1'b1;
        wait_until(k + 1);
        medir = 1'b0;
        wait_until(tf + gap);
        echo = 1'b1;
        if (medir_extra) begin
            meio = tf + gap + w / 2;
            wait_until(meio);
            medir = 1'b1;
            wait_until(meio + 1);
            medir = 1'b0;
        end
        if (w <= MAXE) wait_until(tf + gap + w);
        else wait_until(busy_hi + 2);
        echo = 1'b0;
        wait_until(busy_hi + 6);
        med_cur = med_new;
    endtask

    task automatic sem_echo();
        int k, tf;
        @(posedge clock);
        #1;
        k         = cyc;
        trig_lo   = k + 2;
        trig_hi   = k + TRIG + 1;
        tf        = k + TRIG + 2;
        busy_lo   = k + 1;
        busy_hi   = tf + TOUT;
        tout_at   = tf + TOUT;
        pronto_at = -1;
        med_old   = med_cur;
        med_new   = med_cur;
        medir     = 1'b1;
        wait_until(k + 1);
        medir = 1'b0;
        wait_until(busy_hi + 6);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        medir = 1'b0;
        echo  = 1'b0;
        trig_lo = 1; trig_hi = 0; busy_lo = 1; busy_hi = 0;
        pronto_at = -1; tout_at = -1; med_switch = 0;
        med_old = 12'h000; med_new = 12'h000; med_cur = 12'h000;
        repeat (3) @(negedge clock);
        check("rst_trigger", {31'b0, trigger}, 32'd0);
        check("rst_pronto", {31'b0, pronto}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_ocupado", {31'b0, ocupado}, 32'd0);
        check("rst_medida", {20'b0, medida}, 32'h000);
        check("rst_estado", {28'b0, db_estado}, 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_on = 1'b1;

        medicao(50, 1100, 1'b1);
        check("lit_100", {20'b0, medida}, 32'h100);
        medicao(10, 5, 1'b0);
        check("lit_001", {20'b0, medida}, 32'h001);
        medicao(7, 4, 1'b0);
        check("lit_000", {20'b0, medida}, 32'h000);
        medicao(3, 16, 1'b0);
        check("lit_002", {20'b0, medida}, 32'h002);
        medicao(0, 7290, 1'b0);
        check("lit_663", {20'b0, medida}, 32'h663);
        medicao(20, 11000, 1'b0);
        check("lit_999", {20'b0, medida}, 32'h999);
        medicao(5, 16, 1'b0);
        medicao(5, MAXE, 1'b0);
        check("lit_max_store", {20'b0, medida}, 32'h999);
        medicao(5, 16, 1'b0);
        medicao(5, MAXE + 1000, 1'b0);
        check("lit_abort_keep", {20'b0, medida}, 32'h002);
        sem_echo();
        check("lit_noecho_keep", {20'b0, medida}, 32'h002);

        for (int i = 0; i < 12; i++) begin
            medicao(int'($urandom_range(0, 300)), int'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)));
        end

        chk_on = 1'b0;
        @(posedge clock);
        #1;
        k = cyc;
        medir = 1'b1;
        wait_until(k + 1);
        medir = 1'b0;
        wait_until(k + 9);
        check("trig_mid", {31'b0, trigger}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_trigger", {31'b0, trigger}, 32'd0);
        check("rst_mid_estado", {28'b0, db_estado}, 32'd0);
        check("rst_mid_ocupado", {31'b0, ocupado}, 32'd0);
        check("rst_mid_medida", {20'b0, medida}, 32'h000);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_trigger", {31'b0, trigger}, 32'd0);
        check("post_rst_estado", {28'b0, db_estado}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
